// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types for the RC4 keystream XOR stage.
// Optional feature macro: RC4_DROP_EN (adds the DROP state and its default count).
package rc4_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_INIT = 3'd1,
`ifdef RC4_DROP_EN
        ST_DROP      = 3'd2,
`endif
        ST_RUN       = 3'd3,
        ST_DRAIN     = 3'd4
    } state_t;

`ifdef RC4_DROP_EN
    localparam int DROP_N_DEFAULT = 256;
`endif

endpackage

// File: rtl/rc4_ks_fifo.sv
// rc4_ks_fifo: small synchronous FIFO buffering keystream bytes.
// Pushes into a full FIFO and pops from an empty FIFO are ignored;
// flush empties the FIFO and takes priority over push/pop.
module rc4_ks_fifo
    import rc4_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    byte_t            mem_q [DEPTH];
    byte_t            mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next storage, pointer and occupancy values from push/pop/flush.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rc4_xor_stage.sv
// rc4_xor_stage: buffers RC4 keystream bytes and XORs them with a
// valid/ready plaintext stream, sequencing the generator's rdy/done
// handshake once per message of msg_len bytes.
// Optional feature macro: RC4_DROP_EN (discard DROP_N keystream bytes
// at the start of each message, i.e. RC4-drop[N]).
module rc4_xor_stage
    import rc4_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 16
`ifdef RC4_DROP_EN
    ,
    parameter int DROP_N = DROP_N_DEFAULT
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    output logic             busy,
    output logic             done,
    input  logic             ks_init_done,
    input  logic             ks_valid,
    input  logic [7:0]       ks_data,
    output logic             ks_rdy,
    output logic             ks_done,
    input  logic             din_valid,
    input  logic [7:0]       din,
    output logic             din_ready,
    output logic             dout_valid,
    output logic [7:0]       dout,
    input  logic             dout_ready,
    output logic             overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] RDY_MAX = CNT_W'(DEPTH - 2);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    byte_t            dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic             ks_done_q, ks_done_d;

`ifdef RC4_DROP_EN
    localparam int DROP_W = $clog2(DROP_N + 1);
    localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'(DROP_N - 1);
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
`endif

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    rc4_ks_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .pop  (fifo_pop),
        .flush(fifo_flush),
        .din  (ks_data),
        .dout (fifo_head),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign ks_done    = ks_done_q;
    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
    assign overflow   = overflow_q;

    // Message sequencing, keystream buffering, XOR datapath and handshakes.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overflow_d   = overflow_q;
        done_d       = 1'b0;
        ks_done_d    = 1'b0;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        fifo_flush   = 1'b0;
        ks_rdy       = 1'b0;
        din_ready    = 1'b0;
`ifdef RC4_DROP_EN
        drop_cnt_d   = drop_cnt_q;
`endif

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (msg_len != '0) begin
                        remaining_d = msg_len;
                        state_d     = ST_WAIT_INIT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            ST_WAIT_INIT: begin
                if (ks_init_done) begin
`ifdef RC4_DROP_EN
                    drop_cnt_d = '0;
                    state_d    = ST_DROP;
`else
                    state_d    = ST_RUN;
`endif
                end
            end

`ifdef RC4_DROP_EN
            ST_DROP: begin
                ks_rdy = 1'b1;
                if (ks_valid) begin
                    if (drop_cnt_q == DROP_LAST) begin
                        drop_cnt_d = '0;
                        state_d    = ST_RUN;
                    end else begin
                        drop_cnt_d = drop_cnt_q + DROP_W'(1);
                    end
                end
            end
`endif

            ST_RUN: begin
                ks_rdy    = (fifo_count <= RDY_MAX);
                din_ready = !fifo_empty && (!dout_valid_q || dout_ready) &&
                            (remaining_q != '0);
                if (ks_valid) begin
                    if (fifo_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                    end
                end
                if (din_valid && din_ready) begin
                    fifo_pop     = 1'b1;
                    dout_d       = din ^ fifo_head;
                    dout_valid_d = 1'b1;
                    remaining_d  = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (!dout_valid_q || dout_ready) begin
                    done_d     = 1'b1;
                    ks_done_d  = 1'b1;
                    fifo_flush = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and datapath registers, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            ks_done_q    <= 1'b0;
`ifdef RC4_DROP_EN
            drop_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
            ks_done_q    <= ks_done_d;
`ifdef RC4_DROP_EN
            drop_cnt_q   <= drop_cnt_d;
`endif
        end
    end

endmodule
